fmul_issue: RTL

Issue/collect stage around the one-cycle `fmul` pipeline; `fmul` has no stall and no reset. It accepts operand pairs from the FPU dispatcher over a valid/ready handshake and drives them into `fmul` in the cycle of acceptance. It tracks each operation's tag through a latency-matched valid/tag shift register and captures every `fmul` result into a small FIFO. Results are presented downstream over a second valid/ready handshake, and credit-based admission guarantees no result is ever lost under backpressure.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_res_fifo.sv | 58 +++++
 rtl/fmul_issue.sv | 86 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and types shared by the FPU issue/collect stages
package fpu_pkg;

    localparam int FMUL_LAT = 1;

    typedef logic [31:0] float32_t;

    // Width of a result FIFO entry holding a product and its tag.
    function automatic int res_w(input int tag_w);
        return 32 + tag_w;
    endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: generic synchronous circular-buffer FIFO for FPU results
module fpu_res_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rd];

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push)
                wr <= nxt(wr);
            if (do_pop)
                rd <= nxt(rd);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset since count masks stale entries.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr] <= din;
    end

    // A push into a full FIFO without a matching pop would lose data.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && !do_pop && count == CW'(DEPTH)))
            else $error("fpu_res_fifo overflow");
    end

endmodule

// File: rtl/fmul_issue.sv
// fmul_issue: credit-checked issue into fmul with in-order result collection
module fmul_issue
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  float32_t         in_x1,
    input  float32_t         in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output float32_t         fmul_x1,
    output float32_t         fmul_x2,
    input  float32_t         fmul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output float32_t         out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = $clog2(DEPTH + FMUL_LAT + 1);
    localparam int RW = res_w(TAG_W);

    logic                issue;
    logic                pop;
    logic [FMUL_LAT-1:0] vld;
    logic [TAG_W-1:0]    tg [FMUL_LAT];
    logic [CW-1:0]       count;
    logic [UW-1:0]       used;
    logic [RW-1:0]       head;

    assign fmul_x1   = in_x1;
    assign fmul_x2   = in_x2;
    assign used      = UW'(count) + UW'($countones(vld));
    assign in_ready  = !rst && (used < UW'(DEPTH));
    assign issue     = in_valid && in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign busy      = out_valid || (|vld);
    assign out_y     = head[RW-1:TAG_W];
    assign out_tag   = head[TAG_W-1:0];

    // Valid bits track which fmul slots hold a real product; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= issue;
            for (int i = 1; i < FMUL_LAT; i++)
                vld[i] <= vld[i-1];
        end
    end

    // Tags ride alongside the valid bits; their value is ignored when invalid.
    always_ff @(posedge clk) begin
        tg[0] <= in_tag;
        for (int i = 1; i < FMUL_LAT; i++)
            tg[i] <= tg[i-1];
    end

    // Issued-but-unpopped operations must never exceed the FIFO capacity.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (used <= UW'(DEPTH))
            else $error("fmul_issue credit overrun");
    end

    fpu_res_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld[FMUL_LAT-1]),
        .pop   (pop),
        .din   ({fmul_y, tg[FMUL_LAT-1]}),
        .dout  (head),
        .count (count)
    );

endmodule
